// File: rtl/sdp_ram_pkg.sv
// Shared definitions for the byte-enable simple dual-port RAM.
// Holds the FSM encoding, the collision mode constants and the address-width helper.
package sdp_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam int COLLISION_READ_OLD    = 0;
    localparam int COLLISION_WRITE_FIRST = 1;

    // Address width for a given depth; never less than one bit.
    function automatic int clogb2_ceil(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sdp_ram_be_sync_rd_pipe.sv
// Extra read-latency stages: a shift line of data, valid and, with SDPRAM_PARITY_EN,
// per-byte parity error. Data only moves with a valid, so the output holds between reads.
module sdp_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
`ifdef SDPRAM_PARITY_EN
    ,
    parameter int NUM_BYTES  = 4
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
`ifdef SDPRAM_PARITY_EN
    input  logic [NUM_BYTES-1:0]  in_perr,
    output logic [NUM_BYTES-1:0]  out_perr,
`endif
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  v_q [STAGES];
    logic [DATA_WIDTH-1:0] d_q [STAGES];
`ifdef SDPRAM_PARITY_EN
    logic [NUM_BYTES-1:0]  p_q [STAGES];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s] <= 1'b0;
                d_q[s] <= '0;
`ifdef SDPRAM_PARITY_EN
                p_q[s] <= '0;
`endif
            end
        end else begin
            v_q[0] <= in_valid;
            if (in_valid) begin
                d_q[0] <= in_data;
            end
`ifdef SDPRAM_PARITY_EN
            p_q[0] <= in_valid ? in_perr : '0;
`endif
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
                if (v_q[s-1]) begin
                    d_q[s] <= d_q[s-1];
                end
`ifdef SDPRAM_PARITY_EN
                p_q[s] <= v_q[s-1] ? p_q[s-1] : '0;
`endif
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
`ifdef SDPRAM_PARITY_EN
    assign out_perr  = p_q[STAGES-1];
`endif

endmodule

// File: rtl/sdp_ram_be_sync.sv
// Single-clock simple dual-port RAM with byte enables, 1..3 cycle read latency,
// selectable collision behaviour and a clear sweep after reset. Optional parity: SDPRAM_PARITY_EN.
module sdp_ram_be_sync
    import sdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_WIDTH     = 8,
    parameter int RAM_DEPTH      = 1024,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = COLLISION_READ_OLD,
    localparam int NUM_BYTES     = DATA_WIDTH / BYTE_WIDTH,
    localparam int ADDR_W        = clogb2_ceil(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [NUM_BYTES-1:0]  wr_be_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  init_done_o
`ifdef SDPRAM_PARITY_EN
    ,
    output logic [NUM_BYTES-1:0]  rd_perr_o
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(RAM_DEPTH - 1);

    state_e                state_q;
    logic [ADDR_W-1:0]     clr_cnt_q;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  wr_fire, rd_fire, collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
`ifdef SDPRAM_PARITY_EN
    logic [NUM_BYTES-1:0]  par_mem [RAM_DEPTH];
    logic [NUM_BYTES-1:0]  rd_perr, s1_perr_q;
`endif

    assign wr_fire = (state_q == ST_READY) && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_L);
    assign rd_fire = (state_q == ST_READY) && rd_en_i;
    assign collide = wr_fire && (wr_addr_i == rd_addr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            init_done_o <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_q     <= ST_READY;
                init_done_o <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset branch so it maps onto block RAM; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_cnt_q] <= '0;
`ifdef SDPRAM_PARITY_EN
            par_mem[clr_cnt_q] <= '0;
`endif
        end else if (wr_fire) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_be_i[k]) begin
                    mem[wr_addr_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDPRAM_PARITY_EN
                    par_mem[wr_addr_i][k] <= ^wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
`endif
                end
            end
        end
    end

    // Array word seen by a read this cycle; write-first mode overlays the enabled lanes.
    always_comb begin
        rd_word = '0;
`ifdef SDPRAM_PARITY_EN
        rd_perr = '0;
`endif
        if ({1'b0, rd_addr_i} < DEPTH_L) begin
            rd_word = mem[rd_addr_i];
`ifdef SDPRAM_PARITY_EN
            for (int k = 0; k < NUM_BYTES; k++) begin
                rd_perr[k] = par_mem[rd_addr_i][k] ^ (^rd_word[k*BYTE_WIDTH +: BYTE_WIDTH]);
            end
`endif
            if ((COLLISION_MODE == COLLISION_WRITE_FIRST) && collide) begin
                for (int k = 0; k < NUM_BYTES; k++) begin
                    if (wr_be_i[k]) begin
                        rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef SDPRAM_PARITY_EN
                        rd_perr[k] = 1'b0;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
`ifdef SDPRAM_PARITY_EN
            s1_perr_q  <= '0;
`endif
        end else begin
            s1_valid_q <= rd_fire;
            if (rd_fire) begin
                s1_data_q <= rd_word;
            end
`ifdef SDPRAM_PARITY_EN
            s1_perr_q <= rd_fire ? rd_perr : '0;
`endif
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign rd_valid_o = s1_valid_q;
            assign rd_data_o  = s1_data_q;
`ifdef SDPRAM_PARITY_EN
            assign rd_perr_o  = s1_perr_q;
`endif
        end else begin : g_pipe
            sdp_rd_pipe #(
                .DATA_WIDTH (DATA_WIDTH),
                .STAGES     (RD_LATENCY - 1)
`ifdef SDPRAM_PARITY_EN
                ,
                .NUM_BYTES  (NUM_BYTES)
`endif
            ) u_pipe (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .in_valid  (s1_valid_q),
                .in_data   (s1_data_q),
`ifdef SDPRAM_PARITY_EN
                .in_perr   (s1_perr_q),
                .out_perr  (rd_perr_o),
`endif
                .out_valid (rd_valid_o),
                .out_data  (rd_data_o)
            );
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_be_sync.sv
// Directed bench: dut_a is 1024 deep, latency 1, read-old; dut_b is 1000 deep, latency 3,
// write-first. Both share one stimulus stream.
module tb_sdp_ram_be_sync;
    import sdp_ram_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_be_i = '0;
    logic [9:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic        rd_en_i = 1'b0;
    logic [9:0]  rd_addr_i = '0;

    logic [31:0] a_data, b_data;
    logic        a_valid, b_valid, a_done, b_done;
`ifdef SDPRAM_PARITY_EN
    logic [3:0]  a_perr, b_perr;
`endif

    int errors = 0;
    int checks = 0;
    int cnt;
    logic seen_b_valid;

    always #5 clk_i = ~clk_i;

    sdp_ram_be_sync #(
        .RAM_DEPTH      (1024),
        .RD_LATENCY     (1),
        .COLLISION_MODE (COLLISION_READ_OLD)
    ) dut_a (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_be_i     (wr_be_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (a_data),
        .rd_valid_o  (a_valid),
        .init_done_o (a_done)
`ifdef SDPRAM_PARITY_EN
        ,
        .rd_perr_o   (a_perr)
`endif
    );

    sdp_ram_be_sync #(
        .RAM_DEPTH      (1000),
        .RD_LATENCY     (3),
        .COLLISION_MODE (COLLISION_WRITE_FIRST)
    ) dut_b (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_be_i     (wr_be_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .rd_en_i     (rd_en_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (b_data),
        .rd_valid_o  (b_valid),
        .init_done_o (b_done)
`ifdef SDPRAM_PARITY_EN
        ,
        .rd_perr_o   (b_perr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Step one clock; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_init(input string tag);
        cnt = 0;
        seen_b_valid = 1'b0;
        while (!a_done && cnt < 2000) begin
            tick();
            cnt++;
            seen_b_valid = seen_b_valid | b_valid;
            if (cnt == 999)  check({tag, "_b_done_early"}, b_done, 1'b0);
            if (cnt == 1000) check({tag, "_b_done"}, b_done, 1'b1);
        end
        check({tag, "_a_done_cycles"}, cnt, 1024);
        check({tag, "_b_no_valid"}, seen_b_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_a_data", a_data, 32'h0);
        check("rst_a_valid", a_valid, 1'b0);
        check("rst_a_done", a_done, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_b_data", b_data, 32'h0);
        rst_i = 1'b0;

        // Reads during the clear sweep are ignored
        rd_en_i = 1'b1;
        rd_addr_i = 10'd0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt++;
            check("clear_rd_ignored", {a_valid, b_valid}, 2'b00);
        end
        rd_en_i = 1'b0;
        while (!a_done && cnt < 2000) begin
            tick();
            cnt++;
            if (cnt == 999)  check("init_b_done_early", b_done, 1'b0);
            if (cnt == 1000) check("init_b_done", b_done, 1'b1);
        end
        check("init_a_done_cycles", cnt, 1024);

        // Every word reads back as zero
        rd_en_i = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            rd_addr_i = 10'(i);
            tick();
            check("clear_rd_valid", a_valid, 1'b1);
            check("clear_rd_data", a_data, 32'h0);
        end
        rd_en_i = 1'b0;

        // Byte-enable merge
        wr_en_i = 1'b1;
        wr_addr_i = 10'd5;
        wr_data_i = 32'hAABBCCDD;
        wr_be_i = 4'b1111;
        tick();
        wr_data_i = 32'h11223344;
        wr_be_i = 4'b0101;
        tick();
        wr_en_i = 1'b0;
        rd_en_i = 1'b1;
        rd_addr_i = 10'd5;
        tick();
        rd_en_i = 1'b0;
        check("be_a_valid", a_valid, 1'b1);
        check("be_a_data", a_data, 32'hAA22CC44);
        tick();
        check("be_a_hold_valid", a_valid, 1'b0);
        check("be_a_hold_data", a_data, 32'hAA22CC44);
        tick();
        check("be_b_valid", b_valid, 1'b1);
        check("be_b_data", b_data, 32'hAA22CC44);
        tick();

        // Back-to-back reads through the 3-cycle pipe
        wr_en_i = 1'b1;
        wr_be_i = 4'b1111;
        for (int i = 1; i <= 3; i++) begin
            wr_addr_i = 10'(i);
            wr_data_i = 32'hC0DE0000 + 32'(i);
            tick();
        end
        wr_en_i = 1'b0;
        rd_en_i = 1'b1;
        rd_addr_i = 10'd1;
        tick();
        check("lat_b_n1_valid", b_valid, 1'b0);
        check("lat_a_n1_data", a_data, 32'hC0DE0001);
        rd_addr_i = 10'd2;
        tick();
        check("lat_b_n2_valid", b_valid, 1'b0);
        rd_addr_i = 10'd3;
        tick();
        rd_en_i = 1'b0;
        check("lat_b_n3_valid", b_valid, 1'b1);
        check("lat_b_n3_data", b_data, 32'hC0DE0001);
        check("lat_a_n3_data", a_data, 32'hC0DE0003);
        tick();
        check("lat_b_n4_valid", b_valid, 1'b1);
        check("lat_b_n4_data", b_data, 32'hC0DE0002);
        tick();
        check("lat_b_n5_valid", b_valid, 1'b1);
        check("lat_b_n5_data", b_data, 32'hC0DE0003);
        tick();
        check("lat_b_n6_valid", b_valid, 1'b0);
        check("lat_b_n6_hold", b_data, 32'hC0DE0003);
        tick();
        check("lat_b_n7_hold", b_data, 32'hC0DE0003);

        // Collision on addr 7, then read-after-write
        wr_en_i = 1'b1;
        wr_addr_i = 10'd7;
        wr_data_i = 32'hFFFFFFFF;
        wr_be_i = 4'b0011;
        rd_en_i = 1'b1;
        rd_addr_i = 10'd7;
        tick();
        wr_en_i = 1'b0;
        check("col_a_valid", a_valid, 1'b1);
        check("col_a_old", a_data, 32'h00000000);
        tick();
        rd_en_i = 1'b0;
        check("raw_a_new", a_data, 32'h0000FFFF);
        tick();
        check("col_b_valid", b_valid, 1'b1);
        check("col_b_bypass", b_data, 32'h0000FFFF);
        tick();
        check("raw_b_new", b_data, 32'h0000FFFF);
        tick();

        // Out-of-range on the 1000-deep instance
        wr_en_i = 1'b1;
        wr_addr_i = 10'd1010;
        wr_data_i = 32'h12345678;
        wr_be_i = 4'b1111;
        tick();
        wr_en_i = 1'b0;
        rd_en_i = 1'b1;
        rd_addr_i = 10'd1010;
        tick();
        rd_en_i = 1'b0;
        check("oor_a_in_range", a_data, 32'h12345678);
        tick();
        tick();
        check("oor_b_valid", b_valid, 1'b1);
        check("oor_b_zero", b_data, 32'h0);
        tick();

        // Reset one cycle after a read issue
        rd_en_i = 1'b1;
        rd_addr_i = 10'd5;
        tick();
        rd_en_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_b_valid", b_valid, 1'b0);
        check("mid_rst_a_valid", a_valid, 1'b0);
        check("mid_rst_a_data", a_data, 32'h0);
        check("mid_rst_a_done", a_done, 1'b0);
        wait_init("reinit");
        rd_en_i = 1'b1;
        rd_addr_i = 10'd5;
        tick();
        rd_en_i = 1'b0;
        check("reinit_a_valid", a_valid, 1'b1);
        check("reinit_a_data", a_data, 32'h0);
        tick();
        tick();
        check("reinit_b_valid", b_valid, 1'b1);
        check("reinit_b_data", b_data, 32'h0);
        tick();

`ifdef SDPRAM_PARITY_EN
        // Corrupt one stored bit in lane 1 of addr 3
        dut_a.mem[3][9] = ~dut_a.mem[3][9];
        rd_en_i = 1'b1;
        rd_addr_i = 10'd3;
        tick();
        rd_en_i = 1'b0;
        check("par_a_valid", a_valid, 1'b1);
        check("par_a_perr", a_perr, 4'b0010);
        tick();
        check("par_a_idle_perr", a_perr, 4'b0000);
        tick();
        check("par_b_valid", b_valid, 1'b1);
        check("par_b_perr", b_perr, 4'b0000);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
